booth_div16_seq: RTL and testbench
==================================

Name: booth_div16_seq

Overview:
- Sequential radix-2 non-restoring divider: the inverse operation of the datapath's Booth-4/Wallace 16x16 multiplier.
- Takes a WIDTH-bit dividend and divisor over a valid/ready handshake and produces quotient and remainder after a fixed iteration count.
- Sits beside the multiplier in the arithmetic unit and shares its operand/result handshake style.

Parameters:
- WIDTH, 16, operand/result width in bits (even, >= 4).
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- sys_clk  input  1  system clock, rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- is_signed  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with operands.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts result.
- quotient  output  WIDTH  quotient.
- remainder  output  WIDTH  remainder.
- div_by_zero  output  1  result came from divisor == 0.

Behaviour:
- Reset (async, sys_rst_n low):
  - State is IDLE.
  - out_valid, quotient, remainder and div_by_zero are 0. in_ready is 1.
  - Internal registers and the counter are cleared.
  - Reset asserted mid-operation aborts the operation immediately. No result is produced.
- in_ready = (state == IDLE), decoded combinationally from the state register.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - An accept is a rising edge with in_valid && in_ready.
  - On accept, latch dividend, divisor and is_signed, then go to PREP.
- PREP (1 cycle):
  - Compute magnitudes: two's-complement negation when is_signed and MSB = 1.
  - Record the quotient sign (dividend MSB XOR divisor MSB) and the remainder sign (dividend MSB).
  - Clear the partial remainder (WIDTH+1 bits) and load the counter with WIDTH.
  - If divisor == 0, go to DONE. Otherwise go to CALC.
- CALC (exactly WIDTH cycles):
  - Each cycle, shift {partial remainder, quotient register} left by one.
  - Add or subtract the divisor magnitude according to the partial remainder sign.
  - The new quotient bit = inverted sign of the result.
  - Decrement the counter. When the counter reaches 1, go to FIX.
- FIX (1 cycle):
  - If the partial remainder is negative, add the divisor magnitude back.
  - Apply signs: negate the quotient if the quotient sign is 1; negate the remainder if the remainder sign is 1.
  - Register the results to the outputs and go to DONE.
- DONE:
  - out_valid = 1. quotient, remainder and div_by_zero stay stable.
  - On out_valid && out_ready, go to IDLE with out_valid = 0 next cycle. Outputs keep their last values.
- Latency:
  - Normal operation: out_valid rises WIDTH+3 rising edges after the accepting edge (19 for WIDTH=16).
  - Divide-by-zero: out_valid rises 2 edges after the accepting edge.
- No pipelining: a new accept is possible only after the result handshake, so there is at least 1 IDLE cycle between operations.
- Divide-by-zero result: quotient = all ones, remainder = dividend (raw input), div_by_zero = 1. Applies in both signed and unsigned modes.
- Signed rounding: the quotient truncates toward zero, and a nonzero remainder takes the dividend's sign.
- Signed overflow (-2^(WIDTH-1) / -1): quotient = 0x8000 (wraps), remainder = 0, div_by_zero = 0. No other flag is raised.
- Inputs are ignored in every state except IDLE. Changes to operands while busy have no effect.
- out_ready asserted while not in DONE is ignored.

Optional Feature:
- Macro DIV_CNT_EN.
- Defined:
  - Adds output port div_cnt (16 bits), reset to 0.
  - It increments by 1 on every result handshake (out_valid && out_ready), including divide-by-zero results, and wraps 0xFFFF -> 0x0000.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Unsigned 1000 / 7, is_signed=0, out_ready=1 -> quotient 142, remainder 6, div_by_zero 0; out_valid exactly 19 edges after accept, in_ready low throughout.
- Signed -7 / 2 (0xFFF9 / 0x0002) -> quotient 0xFFFD (-3), remainder 0xFFFF (-1); signed 7 / -2 -> quotient 0xFFFD, remainder 0x0001.
- Divide by zero, dividend 0x1234, divisor 0 -> quotient 0xFFFF, remainder 0x1234, div_by_zero 1, out_valid 2 edges after accept; signed 0x8000 / 0xFFFF -> quotient 0x8000, remainder 0.
- Backpressure: out_ready low for 10 cycles after out_valid rises on 0xFFFF / 0x0001 unsigned -> outputs stable at 0xFFFF / 0x0000, in_ready stays 0, new in_valid ignored; out_ready pulse -> IDLE next cycle.
- Reset mid-CALC (sys_rst_n low at cycle 8 of 50000 / 3) -> out_valid 0, in_ready 1 immediately; next operation 50000 / 3 -> 16666 remainder 2 with normal latency.
- DIV_CNT_EN defined: 3 completed divisions including one divide-by-zero -> div_cnt = 3; preload by 65535 handshakes -> wraps to 0.

Source files
------------

// File: rtl/booth_div16_seq.sv
// Sequential radix-2 non-restoring divider, signed/unsigned, valid/ready on both sides.
// Optional `DIV_CNT_EN adds a 16-bit count of completed result handshakes (port div_cnt).
module booth_div16_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
`ifdef DIV_CNT_EN
  ,
  output logic [15:0]      div_cnt
`endif
);

  typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   dmag_q, dmag_d;
  logic [WIDTH:0]     p_q, p_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     p_shift, p_step, p_fix;
  logic               neg_a, neg_b;

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  // Partial remainder may transiently wrap after the shift; the add/sub result
  // always lands back in [-D, D), so modulo-2^(WIDTH+1) arithmetic is exact.
  assign p_shift = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign p_step  = p_q[WIDTH] ? (p_shift + {1'b0, dmag_q}) : (p_shift - {1'b0, dmag_q});
  assign p_fix   = p_q[WIDTH] ? (p_q + {1'b0, dmag_q}) : p_q;
  assign neg_a   = sgn_q & a_q[WIDTH-1];
  assign neg_b   = sgn_q & b_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    dmag_d  = dmag_q;
    p_d     = p_q;
    q_d     = q_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = dividend;
          b_d     = divisor;
          sgn_d   = is_signed;
          state_d = StPrep;
        end
      end
      StPrep: begin
        q_d    = neg_a ? -a_q : a_q;
        dmag_d = neg_b ? -b_q : b_q;
        qneg_d = neg_a ^ neg_b;
        rneg_d = neg_a;
        p_d    = '0;
        cnt_d  = CNT_W'(WIDTH);
        if (b_q == '0) begin
          quo_d   = '1;
          rem_d   = a_q;
          dbz_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StCalc;
        end
      end
      StCalc: begin
        p_d   = p_step;
        q_d   = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        p_d     = p_fix;
        quo_d   = qneg_q ? -q_q : q_q;
        rem_d   = rneg_q ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
        dbz_d   = 1'b0;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      dmag_q  <= '0;
      p_q     <= '0;
      q_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      dmag_q  <= dmag_d;
      p_q     <= p_d;
      q_q     <= q_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

`ifdef DIV_CNT_EN
  logic [15:0] hs_cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      hs_cnt_q <= hs_cnt_q + 16'd1;
    end
  end

  assign div_cnt = hs_cnt_q;
`endif

endmodule

// File: tb/tb_booth_div16_seq.sv
// Self-checking bench for booth_div16_seq: directed table, corner sequences and
// random operands against an integer-arithmetic reference.
module tb_booth_div16_seq;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        is_signed;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
`ifdef DIV_CNT_EN
  logic [15:0] div_cnt;
`endif

  booth_div16_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
`ifdef DIV_CNT_EN
    ,
    .div_cnt    (div_cnt)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_hs  = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] eq;
    logic [15:0] er;
    logic        ez;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer division; SV int '/' truncates toward zero and
  // '%' takes the dividend's sign, matching the required signed semantics.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic z);
    int sa, sb, qi, ri;
    if (b == 16'd0) begin
      q = 16'hFFFF;
      r = a;
      z = 1'b1;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      qi = sa / sb;
      ri = sa % sb;
      q  = qi[15:0];
      r  = ri[15:0];
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge sys_clk);
      #1;
      guard++;
    end
    check("in_ready_before_accept", in_ready, 1);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge sys_clk);
    #1;
    in_valid  = 1'b0;
    dividend  = 16'($urandom);
    divisor   = 16'($urandom);
    is_signed = 1'($urandom);
  endtask

  // Counts edges with the accepting edge as edge 1.
  task automatic wait_valid(output int lat);
    logic busy_ok;
    busy_ok = 1'b1;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge sys_clk);
      #1;
      lat++;
    end
    check("in_ready_low_while_busy", busy_ok, 1);
    check("out_valid_within_bound", out_valid, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    out_ready = 1'b0;
    n_hs++;
    check("out_valid_low_after_hs", out_valid, 0);
    check("in_ready_high_after_hs", in_ready, 1);
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic s);
    logic [15:0] eq, er, q, r;
    logic        ez, z;
    int          lat;
    model(a, b, s, eq, er, ez);
    start_op(a, b, s);
    wait_valid(lat);
    q = quotient;
    r = remainder;
    z = div_by_zero;
    handshake();
    check({tag, "_quotient"}, q, eq);
    check({tag, "_remainder"}, r, er);
    check({tag, "_dbz"}, z, ez);
    check({tag, "_latency"}, lat, ez ? 2 : 19);
    check({tag, "_quotient_held"}, quotient, eq);
  endtask

  vec_t vecs[7];

  initial begin
    logic [15:0] q, r, a, b;
    logic        z, s;
    int          lat;

    vecs[0] = '{16'd1000,  16'd7,      1'b0, 16'd142,   16'd6,     1'b0};
    vecs[1] = '{16'hFFF9,  16'h0002,   1'b1, 16'hFFFD,  16'hFFFF,  1'b0};
    vecs[2] = '{16'h0007,  16'hFFFE,   1'b1, 16'hFFFD,  16'h0001,  1'b0};
    vecs[3] = '{16'h1234,  16'h0000,   1'b0, 16'hFFFF,  16'h1234,  1'b1};
    vecs[4] = '{16'h8000,  16'hFFFF,   1'b1, 16'h8000,  16'h0000,  1'b0};
    vecs[5] = '{16'hFFFF,  16'h0001,   1'b0, 16'hFFFF,  16'h0000,  1'b0};
    vecs[6] = '{16'h8765,  16'h0000,   1'b1, 16'hFFFF,  16'h8765,  1'b1};

    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
`ifdef DIV_CNT_EN
    check("rst_div_cnt", div_cnt, 0);
`endif
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_valid(lat);
      q = quotient;
      r = remainder;
      z = div_by_zero;
      handshake();
      check($sformatf("vec%0d_quotient", i), q, vecs[i].eq);
      check($sformatf("vec%0d_remainder", i), r, vecs[i].er);
      check($sformatf("vec%0d_dbz", i), z, vecs[i].ez);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].ez ? 2 : 19);
    end

    // Backpressure: result must hold and new operands must be ignored.
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_valid(lat);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      dividend = 16'd9;
      divisor  = 16'd3;
      @(posedge sys_clk);
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_quotient", quotient, 16'hFFFF);
      check("bp_remainder", remainder, 16'h0000);
    end
    in_valid = 1'b0;
    handshake();
    check("bp_quotient_after", quotient, 16'hFFFF);

    // Reset in the middle of CALC aborts without a result.
    start_op(16'd50000, 16'd3, 1'b0);
    repeat (7) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_quotient", quotient, 0);
    n_hs = 0;
    #2;
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    run_and_check("post_rst", 16'd50000, 16'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      if (i % 8 == 0)      b = 16'd0;
      else if (i % 3 == 0) b = 16'($urandom_range(1, 15));
      else                 b = 16'($urandom);
      s = 1'($urandom);
      if (i == 5) begin
        a = 16'h8000;
        b = 16'hFFFF;
        s = 1'b1;
      end
      run_and_check($sformatf("rnd%0d", i), a, b, s);
    end

`ifdef DIV_CNT_EN
    check("div_cnt_total", div_cnt, n_hs[15:0]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
